// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared lane constants and state/mode encodings for the stream dispatcher.
package dispatch_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W = 2;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic {MODE_RR = 1'b0, MODE_DEST = 1'b1} mode_t;
endpackage

// File: rtl/demux_1to4.sv
// demux_1to4: steers a single data bit onto one of four outputs selected by s_i.
module demux_1to4 (
  input  logic       d_i,
  input  logic [1:0] s_i,
  output logic [3:0] y_o
);
  assign y_o = {3'b000, d_i} << s_i;
endmodule

// File: rtl/rr_lane_pick.sv
// rr_lane_pick: first enabled lane starting at the pointer, scanning upward modulo NUM_LANES.
module rr_lane_pick
  import dispatch_pkg::*;
(
  input  logic [LANE_W-1:0]    ptr_i,
  input  logic [NUM_LANES-1:0] lane_en_i,
  output logic [LANE_W-1:0]    lane_o,
  output logic                 valid_o
);
  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0]   rot;
  logic [LANE_W-1:0]      ofs;
  // rot[k] is the enable of lane (ptr+k) mod NUM_LANES
  assign dbl = {lane_en_i, lane_en_i};
  assign rot = NUM_LANES'(dbl >> ptr_i);
  always_comb begin
    ofs = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  end
  assign lane_o  = ptr_i + ofs;
  assign valid_o = |lane_en_i;
endmodule

// File: rtl/demux_stream_dispatcher.sv
// demux_stream_dispatcher: holds one stream word and steers it to a lane by burst round-robin or explicit destination.
module demux_stream_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANE_W-1:0]    in_dest,
  input  logic                 mode,
  input  logic [NUM_LANES-1:0] lane_en,
  output logic [DATA_W-1:0]    out_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [LANE_W-1:0]    sel,
  output logic                 drop
);
  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [LANE_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, rr_lane, tgt;
  logic [7:0]         cnt_q, cnt_d, cnt_n;
  logic               drop_q, drop_d, hold, xfer, acc, keep, rr_ok, rr_upd, dest_mode, burst_end;
  rr_lane_pick u_pick (
    .ptr_i    (ptr_q),
    .lane_en_i(lane_en),
    .lane_o   (rr_lane),
    .valid_o  (rr_ok)
  );
  demux_1to4 u_demux (
    .d_i(hold),
    .s_i(sel_q),
    .y_o(out_valid)
  );
  assign dest_mode = mode_t'(mode) == MODE_DEST;
  assign hold      = state_q == HOLD;
  assign in_ready  = rst_n && (hold ? out_ready[sel_q] : (|lane_en || dest_mode));
  assign xfer      = hold && out_ready[sel_q];
  assign acc       = in_valid && in_ready;
  assign tgt       = dest_mode ? in_dest : rr_lane;
  assign keep      = dest_mode ? lane_en[in_dest] : rr_ok;
  assign rr_upd    = acc && !dest_mode && rr_ok;
  // a burst restarts whenever the round-robin target moves away from the pointer
  assign cnt_n     = (tgt != ptr_q) ? 8'd1 : cnt_q + 8'd1;
  assign burst_end = cnt_n == 8'(BURST_LEN);
  always_comb begin
    state_d = (acc && keep) ? HOLD : xfer ? IDLE : state_q;
    data_d  = (acc && keep) ? in_data : data_q;
    sel_d   = (acc && keep) ? tgt : sel_q;
    drop_d  = acc && !keep;
    ptr_d   = !rr_upd ? ptr_q : burst_end ? tgt + 2'd1 : tgt;
    cnt_d   = !rr_upd ? cnt_q : burst_end ? 8'd0 : cnt_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      drop_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_data = data_q;
  assign sel      = sel_q;
  assign drop     = drop_q;
endmodule

// File: tb/tb_demux_stream_dispatcher.sv
// tb_demux_stream_dispatcher: scoreboard bench with a lane-level reference model of the dispatcher.
module tb_demux_stream_dispatcher;
  localparam int BL = 4;
  logic       clk, rst_n;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_ready, mode, drop;
  logic [1:0] in_dest, sel;
  logic [3:0] lane_en, out_valid, out_ready;
  int total = 0, bad = 0;
  typedef struct {logic [1:0] lane; logic [7:0] data;} exp_t;
  exp_t sb[$];
  logic       m_held = 0, m_drop = 0;
  logic [1:0] m_lane = 0;
  logic [7:0] m_data = 0;
  int         m_ptr = 0, m_cnt = 0;

  demux_stream_dispatcher #(.DATA_W(8), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .mode(mode), .lane_en(lane_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .drop(drop)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    logic [3:0] ev;
    ev = m_held ? (4'b0001 << m_lane) : 4'b0000;
    chk("out_valid", out_valid, ev);
    chk("drop", drop, m_drop);
    if (m_held) begin
      chk("sel", sel, m_lane);
      chk("out_data", out_data, m_data);
    end
  endtask

  // one clock cycle: check registered outputs, drive inputs, check in_ready, advance model
  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] dst,
                       input logic md, input logic [3:0] en, input logic [3:0] rdy);
    logic er, ac;
    int t;
    @(negedge clk);
    chk_outputs();
    in_valid = v; in_data = d; in_dest = dst; mode = md; lane_en = en; out_ready = rdy;
    #1;
    er = m_held ? rdy[m_lane] : (|en || md);
    chk("in_ready", in_ready, er);
    ac = v && er;
    m_drop = 0;
    if (m_held && rdy[m_lane]) m_held = 0;
    if (ac) begin
      t = -1;
      if (md) begin
        if (en[dst]) t = dst;
      end else begin
        for (int k = 3; k >= 0; k--) if (en[(m_ptr + k) % 4]) t = (m_ptr + k) % 4;
        if (t >= 0) begin
          if (t != m_ptr) begin m_ptr = t; m_cnt = 1; end
          else m_cnt++;
          if (m_cnt == BL) begin m_ptr = (t + 1) % 4; m_cnt = 0; end
        end
      end
      if (t < 0) m_drop = 1;
      else begin
        m_held = 1; m_lane = t[1:0]; m_data = d;
        sb.push_back('{lane: t[1:0], data: d});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    chk_outputs();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_drop", drop, 1'b0);
    if (m_held) void'(sb.pop_back());
    m_held = 0; m_drop = 0; m_ptr = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [3:0] hs;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      hs = out_valid & out_ready;
      if (hs != 4'b0000) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow got=%b exp=none at %0t", hs, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_lane", hs, 4'b0001 << e.lane);
          chk("sb_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; in_dest = 0; mode = 0; lane_en = 4'hF; out_ready = 4'hF;
    #3;
    chk("reset_out_valid", out_valid, 4'b0000);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_sel", sel, 2'd0);
    chk("reset_drop", drop, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 2'd0, 1'b0, 4'hF, 4'hF);
    idle(2);
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h20 + i), 2'd0, 1'b0, 4'hA, 4'hF);
    idle(2);
    cycle(1, 8'h31, 2'd2, 1'b1, 4'hF, 4'hF);
    cycle(1, 8'h32, 2'd0, 1'b1, 4'hF, 4'hF);
    cycle(1, 8'h33, 2'd3, 1'b1, 4'hF, 4'hF);
    idle(2);
    cycle(1, 8'hAA, 2'd1, 1'b1, 4'hD, 4'hF);
    idle(2);
    cycle(1, 8'h55, 2'd2, 1'b1, 4'hF, 4'hF);
    for (int i = 0; i < 5; i++) cycle(1, 8'h66, 2'd0, 1'b1, 4'hF, 4'b0001);
    cycle(1, 8'h66, 2'd0, 1'b1, 4'hF, 4'b0101);
    idle(2);
    cycle(1, 8'h77, 2'd0, 1'b0, 4'h0, 4'hF);
    idle(1);
    cycle(1, 8'h41, 2'd0, 1'b0, 4'hF, 4'hF);
    cycle(1, 8'h42, 2'd0, 1'b0, 4'hF, 4'hF);
    cycle(1, 8'h43, 2'd3, 1'b1, 4'hF, 4'h0);
    reset_mid();
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 2'd0, 1'b0, 4'hF, 4'hF);
    idle(2);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) != 0, 8'($urandom), 2'($urandom), $urandom_range(0, 1) != 0,
            4'($urandom_range(1, 15)), 4'($urandom));
    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
